// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//
// Purpose:
//   Lets NUM_REQ matcher datapath units (distance, score, ...) share one
//   pipelined 16x16 -> 32 multiplier. A round-robin arbiter grants at most
//   one requester per cycle. The granted operands are registered onto the
//   multiplier inputs. A tag pipeline follows each operation through the
//   multiplier so that each product returns to the requester that issued it.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset (0 = reset)
//   req_valid    per-requester request, held with stable operands until accepted
//   req_a/req_b  packed 16-bit operands, requester i at [16i+15:16i]
//   req_ready    one-hot combinational grant (accept = req_valid & req_ready)
//   mult_a/b     registered operands to the multiplier, 0 when idle
//   mult_product multiplier result, MULT_LAT edges after mult_a/mult_b
//   rsp_valid    registered one-hot result strobe for the issuing requester
//   rsp_product  registered result, holds its value between strobes
//   busy         any operation currently tracked in the tag pipeline
//   op_count     number of accepted operations, wraps at 2^CNT_W

module mult_share_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MULT_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [16*NUM_REQ-1:0]  req_a,
    input  logic [16*NUM_REQ-1:0]  req_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [15:0]            mult_a,
    output logic [15:0]            mult_b,
    input  logic [31:0]            mult_product,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_product,
    output logic                   busy,
    output logic [CNT_W-1:0]       op_count
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Registered state
    logic [ID_W-1:0]    ptr_q,  ptr_d;
    logic [15:0]        mult_a_q, mult_a_d;
    logic [15:0]        mult_b_q, mult_b_d;
    logic [MULT_LAT:0]  tag_valid_q, tag_valid_d;
    logic [ID_W-1:0]    tag_id_q [MULT_LAT+1];
    logic [ID_W-1:0]    tag_id_d [MULT_LAT+1];
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_product_q, rsp_product_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;

    // Arbiter results
    logic               grant_found;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W:0]      cand;
    logic [15:0]        sel_a;
    logic [15:0]        sel_b;

    // Round-robin search starting at the pointer and wrapping at NUM_REQ-1.
    // A grant is only ever issued to a requester whose req_valid is high, so
    // grant_found doubles as the accept strobe for this cycle. The extra bit
    // in cand keeps ptr+k from overflowing before the wrap subtraction.
    always_comb begin
        req_ready   = '0;
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        if (reset) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = {1'b0, ptr_q} + (ID_W+1)'(k);
                if (cand >= (ID_W+1)'(NUM_REQ)) begin
                    cand = cand - (ID_W+1)'(NUM_REQ);
                end
                if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                    grant_found = 1'b1;
                    grant_id    = cand[ID_W-1:0];
                end
            end
            if (grant_found) begin
                req_ready[grant_id] = 1'b1;
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_a = req_a[16*i +: 16];
                sel_b = req_b[16*i +: 16];
            end
        end
    end

    // Next-state logic. The tag pipeline advances every cycle. Stage 0 is
    // loaded at the same edge as the operands, so stage MULT_LAT lines up with
    // the edge that registers the matching product into rsp_product.
    always_comb begin
        ptr_d         = ptr_q;
        op_count_d    = op_count_q;
        mult_a_d      = '0;
        mult_b_d      = '0;
        rsp_valid_d   = '0;
        rsp_product_d = rsp_product_q;

        if (grant_found) begin
            ptr_d      = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
            op_count_d = op_count_q + CNT_W'(1);
            mult_a_d   = sel_a;
            mult_b_d   = sel_b;
        end

        tag_valid_d = {tag_valid_q[MULT_LAT-1:0], grant_found};
        tag_id_d[0] = grant_id;
        for (int k = 1; k <= MULT_LAT; k++) begin
            tag_id_d[k] = tag_id_q[k-1];
        end

        if (tag_valid_q[MULT_LAT]) begin
            rsp_product_d = mult_product;
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_valid_d[i] = (tag_id_q[MULT_LAT] == ID_W'(i));
            end
        end
    end

    // State registers. Reset clears the tag pipeline, which is what drops
    // any in-flight operations: their products are never strobed out.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q         <= '0;
            mult_a_q      <= '0;
            mult_b_q      <= '0;
            tag_valid_q   <= '0;
            rsp_valid_q   <= '0;
            rsp_product_q <= '0;
            op_count_q    <= '0;
            for (int k = 0; k <= MULT_LAT; k++) begin
                tag_id_q[k] <= '0;
            end
        end else begin
            ptr_q         <= ptr_d;
            mult_a_q      <= mult_a_d;
            mult_b_q      <= mult_b_d;
            tag_valid_q   <= tag_valid_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_product_q <= rsp_product_d;
            op_count_q    <= op_count_d;
            for (int k = 0; k <= MULT_LAT; k++) begin
                tag_id_q[k] <= tag_id_d[k];
            end
        end
    end

    assign mult_a      = mult_a_q;
    assign mult_b      = mult_b_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_product = rsp_product_q;
    assign op_count    = op_count_q;
    assign busy        = |tag_valid_q;

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
Shares one pipelined 16x16 Multiplier32 instance among NUM_REQ matching-datapath requesters, such as distance and score units in the finger-vein matcher. Arbitration is round-robin. The block accepts at most one operand pair per cycle and drives it to the multiplier. It tracks the requester ID of every in-flight operation and returns each 32-bit product to the requester that issued it.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MULT_LAT, 2, multiplier latency in clock edges from mult_a/mult_b valid to matching mult_product valid; the multiplier accepts one operation per cycle
CNT_W, 16, width of op_count

Ports:
clk  in  1  clock, rising-edge
reset  in  1  synchronous, active-low reset (0 = reset)
req_valid  in  NUM_REQ  per-requester request; held high with stable operands until accepted
req_a  in  16*NUM_REQ  operand A, requester i at bits [16i+15:16i]
req_b  in  16*NUM_REQ  operand B, same packing
req_ready  out  NUM_REQ  one-hot grant, combinational; accept = req_valid[i] & req_ready[i] at clock edge
mult_a  out  16  operand A to multiplier (registered)
mult_b  out  16  operand B to multiplier (registered)
mult_product  in  32  product from multiplier
rsp_valid  out  NUM_REQ  one-cycle, one-hot result strobe (registered)
rsp_product  out  32  result, valid when any rsp_valid bit is high (registered)
busy  out  1  high while any operation is in flight
op_count  out  CNT_W  total accepted operations, wraps at 2^CNT_W

Behaviour:
- Reset (reset==0 at an edge): req_ready=0, mult_a=0, mult_b=0, rsp_valid=0, rsp_product=0, busy=0, op_count=0, rr pointer=0, tag pipeline cleared.
- Reset mid-operation discards all in-flight operations; no rsp_valid is ever produced for them.
- Arbiter: combinational round-robin. Search starts at pointer p and proceeds p, p+1, ... wrapping at NUM_REQ-1 -> 0. The first i with req_valid[i]=1 gets req_ready[i]=1; all other bits are 0. While reset is active, req_ready=0.
- On an accept of requester g: p <= (g+1) mod NUM_REQ. With no accept, p is unchanged.
- Operand stage: an accept at edge E0 registers mult_a/mult_b <= that requester's operands. With no accept, mult_a/mult_b <= 0.
- Tag pipeline: depth MULT_LAT+1 of {valid, id[clog2(NUM_REQ)-1:0]}, advancing every cycle.
- Response: at edge E0+MULT_LAT+1, rsp_product <= mult_product and rsp_valid <= onehot(id). rsp_valid is visible MULT_LAT+1 cycles after the accept edge (3 at default).
- When no tagged operation completes, rsp_valid=0 and rsp_product holds its last value.
- Throughput: one accept per cycle and one response per cycle. Back-to-back accepts produce back-to-back responses in accept order. There is no backpressure on responses; requesters must always sink them.
- busy = OR of tag pipeline valid bits (registered state, not including the current-cycle grant).
- op_count increments by 1 on each accept and wraps from 2^CNT_W-1 to 0.
- Arithmetic: unsigned; the full 32-bit result is passed through without truncation. The 0xFFFF*0xFFFF result is 0xFFFE0001.
- A requester that drops req_valid before acceptance gets nothing. A requester that holds req_valid after acceptance is treated as a new request.
- The same requester may have multiple operations in flight.

Test Plan:
- Reset, then req_valid=0001 with A0=1000, B0=5 -> req_ready=0001 in the same cycle; rsp_valid=0001 and rsp_product=5000 exactly 3 cycles after the accept edge; op_count=1; busy high for 3 cycles.
- All four requesters held valid (R0 1000x5, R1 250x300, R2 765x8, R3 30x1) -> grants R0,R1,R2,R3 on consecutive cycles; responses 5000, 75000, 6120, 30 on consecutive cycles with rsp_valid 0001, 0010, 0100, 1000.
- Fairness: R1 and R3 held valid permanently, p=2 -> grant order R3, R1, R3, R1, ...; no requester is granted twice in a row while the other waits.
- Boundaries: 0xFFFF x 0xFFFF -> 0xFFFE0001. 0 x 0xFFFF -> 0 with rsp_valid asserted. Idle cycles -> mult_a=mult_b=0 and rsp_valid=0.
- Reset asserted one cycle after two accepts -> no rsp_valid afterwards; op_count=0, busy=0, p=0; a fresh request then completes normally.
- Set CNT_W=4 and issue 17 accepts -> op_count wraps and reads 1.
